// File: rtl/word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
//   Buffers 16-bit result words (high/low byte plus a 2-bit status slice) in a
//   small register FIFO. Each buffered word is replayed as a byte stream under a
//   valid/ready handshake. Words offered while the FIFO is full are dropped and
//   counted.
//
// Optional feature macro: SERIALIZER_STATUS_TAG_EN
//   defined   : each word emits a tag byte {4'hA, 2'b00, status}, then high, then low
//   undefined : each word emits high, then low; status is not stored
//
// Ports
//   sys_clk, sys_reset  : clock; synchronous active-high reset
//   in_data_high/low    : result word bytes
//   in_status           : status slice captured with the word
//   in_strobe           : a word is offered on every cycle this is high
//   out_data/valid/last : byte stream; out_last marks the final byte of a word
//   out_ready           : consumer accepts the byte when out_valid is also high
//   fifo_count          : words currently stored (0..DEPTH)
//   overflow            : sticky, set on the first dropped word
//   drop_count          : dropped-word counter, saturates at 255
// -----------------------------------------------------------------------------
module word_byte_serializer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_reset,
  input  logic [7:0]    in_data_high,
  input  logic [7:0]    in_data_low,
  input  logic [1:0]    in_status,
  input  logic          in_strobe,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic [7:0]    drop_count
);

`ifdef SERIALIZER_STATUS_TAG_EN
  localparam int unsigned WW = 18;
  typedef enum logic [1:0] {
    ST_TAG  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;
  localparam state_e ST_FIRST = ST_TAG;
`else
  localparam int unsigned WW = 16;
  typedef enum logic {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_e;
  localparam state_e ST_FIRST = ST_HIGH;
`endif

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage and state registers
  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  // Combinational helpers
  logic [WW-1:0] wr_word;
  logic [WW-1:0] head_d;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic          hs;
  logic          pop;

`ifdef SERIALIZER_STATUS_TAG_EN
  assign wr_word = {in_status, in_data_high, in_data_low};
`else
  assign wr_word = {in_data_high, in_data_low};
  logic unused_status;
  assign unused_status = ^in_status;
`endif

  // Full always blocks the write, even when the head pops on the same cycle
  assign full  = (count_q == FULL_CNT);
  assign wr_en = in_strobe && !full;
  assign drop  = in_strobe && full;
  assign hs    = out_valid_q && out_ready;
  assign pop   = hs && (state_q == ST_LOW);

  // Next-state logic for pointers, occupancy, drop tracking and emit FSM
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    state_d     = state_q;
    head_d      = '0;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    if (hs) begin
      case (state_q)
`ifdef SERIALIZER_STATUS_TAG_EN
        ST_TAG:  state_d = ST_HIGH;
`endif
        ST_HIGH: state_d = ST_LOW;
        ST_LOW:  state_d = ST_FIRST;
        default: state_d = ST_FIRST;
      endcase
    end

    // Head after this edge: a word written into the slot the read pointer
    // lands on is only possible when the FIFO would otherwise be empty.
    if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = wr_word;
    else                                 head_d = mem_q[rd_ptr_d];

    // Outputs are pre-computed from next-state values so they come straight
    // from flops with no path from out_ready.
    out_valid_d = (count_d != '0);
    out_last_d  = (state_d == ST_LOW);
    if (count_d != '0) begin
      case (state_d)
`ifdef SERIALIZER_STATUS_TAG_EN
        ST_TAG:  out_data_d = {4'hA, 2'b00, head_d[17:16]};
`endif
        ST_HIGH: out_data_d = head_d[15:8];
        ST_LOW:  out_data_d = head_d[7:0];
        default: out_data_d = 8'h00;
      endcase
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= 8'h00;
      state_q     <= ST_FIRST;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge sys_clk) begin
    if (!sys_reset && wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_byte_serializer
//   Directed self-checking bench for word_byte_serializer (DEPTH=8).
//   Follows SERIALIZER_STATUS_TAG_EN to pick 2 or 3 bytes per word.
// -----------------------------------------------------------------------------
module tb_word_byte_serializer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef SERIALIZER_STATUS_TAG_EN
  localparam int BPW = 3;
`else
  localparam int BPW = 2;
`endif

  logic          sys_clk;
  logic          sys_reset;
  logic [7:0]    in_data_high;
  logic [7:0]    in_data_low;
  logic [1:0]    in_status;
  logic          in_strobe;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_data[$];
  logic       exp_last[$];
  logic [7:0] got_data[$];
  logic       got_last[$];
  bit         drain_timeout;

  word_byte_serializer #(.DEPTH(DEPTH)) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .in_data_high (in_data_high),
    .in_data_low  (in_data_low),
    .in_status    (in_status),
    .in_strobe    (in_strobe),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Append the expected byte stream for one word
  function automatic void add_word(input logic [7:0] hi, input logic [7:0] lo,
                                   input logic [1:0] st);
`ifdef SERIALIZER_STATUS_TAG_EN
    exp_data.push_back({4'hA, 2'b00, st});
    exp_last.push_back(1'b0);
`else
    if (st == 2'b11) begin end
`endif
    exp_data.push_back(hi);
    exp_last.push_back(1'b0);
    exp_data.push_back(lo);
    exp_last.push_back(1'b1);
  endfunction

  function automatic logic [7:0] first_byte(input logic [7:0] hi, input logic [1:0] st);
`ifdef SERIALIZER_STATUS_TAG_EN
    return {4'hA, 2'b00, st};
`else
    if (st == 2'b11) return hi;
    return hi;
`endif
  endfunction

  // Collect n accepted bytes (ready constant 1 or random); bounded
  task automatic drain(input int n, input bit rnd);
    int cyc;
    cyc = 0;
    drain_timeout = 1'b0;
    got_data.delete();
    got_last.delete();
    while (got_data.size() < n && cyc < 1000) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    if (got_data.size() < n) drain_timeout = 1'b1;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    in_strobe = 1'b1;
    in_data_high = 8'hFF;
    in_data_low = 8'hFF;
    in_status = 2'b11;
    out_ready = 1'b0;
    step();
    step();
    in_strobe = 1'b0;
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", out_last); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    sys_reset = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_input_ignored: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_single_word();
    exp_data.delete(); exp_last.delete();
    add_word(8'h12, 8'h34, 2'b10);
    in_data_high = 8'h12; in_data_low = 8'h34; in_status = 2'b10;
    in_strobe = 1'b1;
    out_ready = 1'b1;
    step();
    in_strobe = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== exp_data[0]) begin n_fail++; $display("FAIL single_first_byte: got %h expected %h", out_data, exp_data[0]); end
    n_tests++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    drain(BPW, 1'b0);
    n_tests++; if (drain_timeout) begin n_fail++; $display("FAIL single_timeout: got %0d bytes expected %0d", got_data.size(), BPW); end
    for (int i = 0; i < BPW && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL single_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_tests++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_empty: got valid %b count %0d expected 0 0", out_valid, fifo_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] fb;
    exp_data.delete(); exp_last.delete();
    add_word(8'h12, 8'h34, 2'b01);
    fb = first_byte(8'h12, 2'b01);
    in_data_high = 8'h12; in_data_low = 8'h34; in_status = 2'b01;
    out_ready = 1'b0;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== fb || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_c%0d: got valid %b data %h last %b expected 1 %h 0", c, out_valid, out_data, out_last, fb);
      end
      step();
    end
    drain(BPW, 1'b0);
    n_tests++; if (drain_timeout) begin n_fail++; $display("FAIL bp_timeout: got %0d bytes expected %0d", got_data.size(), BPW); end
    for (int i = 0; i < BPW && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL bp_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got valid %b expected 0", out_valid); end
  endtask

  // Fill with 12 words while stalled; then pop the head while pushing (drop)
  task automatic test_overflow_and_simul();
    exp_data.delete(); exp_last.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_data_high = 8'h20 + 8'(i);
      in_data_low  = 8'h40 + 8'(i);
      in_status    = 2'(i);
      in_strobe    = 1'b1;
      if (i < 8) add_word(8'h20 + 8'(i), 8'h40 + 8'(i), 2'(i));
      step();
    end
    in_strobe = 1'b0;
    n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_tests++; if (drop_count !== 8'd4) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 4", drop_count); end

    // Walk word 0 up to its last byte, then pop it while a new word arrives
    got_data.delete(); got_last.delete();
    out_ready = 1'b1;
    for (int k = 0; k < BPW - 1; k++) begin
      got_data.push_back(out_data); got_last.push_back(out_last);
      step();
    end
    n_tests++; if (out_last !== 1'b1 || out_data !== 8'h40) begin n_fail++; $display("FAIL simul_at_low: got last %b data %h expected 1 40", out_last, out_data); end
    got_data.push_back(out_data); got_last.push_back(out_last);
    in_data_high = 8'hEE; in_data_low = 8'hEF; in_status = 2'b11;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    out_ready = 1'b0;
    n_tests++; if (fifo_count !== 4'd7) begin n_fail++; $display("FAIL simul_count: got %0d expected 7", fifo_count); end
    n_tests++; if (drop_count !== 8'd5) begin n_fail++; $display("FAIL simul_drop: got %0d expected 5", drop_count); end
    for (int i = 0; i < BPW; i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL simul_word0_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end

    drain(7 * BPW, 1'b0);
    n_tests++; if (drain_timeout) begin n_fail++; $display("FAIL ovf_drain_timeout: got %0d bytes expected %0d", got_data.size(), 7 * BPW); end
    for (int i = 0; i < 7 * BPW && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[BPW + i] || got_last[i] !== exp_last[BPW + i]) begin
        n_fail++; $display("FAIL ovf_drain_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[BPW + i], exp_last[BPW + i]);
      end
    end
    n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got valid %b overflow %b expected 0 1", out_valid, overflow); end
  endtask

  // 20 words through the 8-deep FIFO with random ready; pushes only when room
  task automatic test_wrap();
    int pushed, mcount, cyc;
    bit do_push, accept, pop_now;
    exp_data.delete(); exp_last.delete();
    got_data.delete(); got_last.delete();
    for (int i = 0; i < 20; i++) add_word(8'h80 + 8'(i), 8'hC0 + 8'(i), 2'(i));
    pushed = 0; mcount = 0; cyc = 0;
    while ((pushed < 20 || got_data.size() < 20 * BPW) && cyc < 3000) begin
      do_push = (pushed < 20) && (mcount < DEPTH) && ($urandom % 3 != 0);
      in_strobe    = do_push;
      in_data_high = 8'h80 + 8'(pushed);
      in_data_low  = 8'hC0 + 8'(pushed);
      in_status    = 2'(pushed);
      out_ready    = 1'($urandom % 2);
      accept  = out_valid && out_ready;
      pop_now = accept && out_last;
      if (accept) begin
        got_data.push_back(out_data); got_last.push_back(out_last);
      end
      step();
      if (do_push) begin mcount++; pushed++; end
      if (pop_now) mcount--;
      cyc++;
    end
    in_strobe = 1'b0;
    out_ready = 1'b0;
    n_tests++; if (got_data.size() != 20 * BPW) begin n_fail++; $display("FAIL wrap_len: got %0d bytes expected %0d", got_data.size(), 20 * BPW); end
    for (int i = 0; i < 20 * BPW && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL wrap_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_tests++; if (drop_count !== 8'd5 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL wrap_end: got drop %0d count %0d expected 5 0", drop_count, fifo_count); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] fb;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data_high = 8'h60 + 8'(i); in_data_low = 8'h70 + 8'(i); in_status = 2'b01;
      in_strobe = 1'b1;
      step();
    end
    in_strobe = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < BPW - 1; k++) step();
    n_tests++; if (out_last !== 1'b1 || out_data !== 8'h70) begin n_fail++; $display("FAIL rmid_pre: got last %b data %h expected 1 70", out_last, out_data); end
    out_ready = 1'b0;
    sys_reset = 1'b1;
    in_strobe = 1'b1;
    step();
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
    n_tests++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_last: got %b %b expected 0 0", out_valid, out_last); end
    n_tests++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got %0d ovf %b expected 0 0", drop_count, overflow); end
    sys_reset = 1'b0;
    in_data_high = 8'h5A; in_data_low = 8'hC3; in_status = 2'b11;
    fb = first_byte(8'h5A, 2'b11);
    step();
    in_strobe = 1'b0;
    n_tests++; if (out_data !== fb || out_last !== 1'b0 || fifo_count !== 4'd1) begin n_fail++; $display("FAIL rmid_first_state: got data %h last %b count %0d expected %h 0 1", out_data, out_last, fifo_count, fb); end
    exp_data.delete(); exp_last.delete();
    add_word(8'h5A, 8'hC3, 2'b11);
    drain(BPW, 1'b0);
    n_tests++; if (drain_timeout) begin n_fail++; $display("FAIL rmid_timeout: got %0d bytes expected %0d", got_data.size(), BPW); end
    for (int i = 0; i < BPW && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL rmid_byte%0d: got %h/last %b expected %h/last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    sys_reset    = 1'b1;
    in_data_high = 8'h00;
    in_data_low  = 8'h00;
    in_status    = 2'b00;
    in_strobe    = 1'b0;
    out_ready    = 1'b0;
    #1;
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow_and_simul();
    test_wrap();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
